// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, bit-period calculation and frame size.
// Used by uart_tx and its bit timer.
package uart_pkg;

   localparam int DATA_BITS = 8;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

   // Clocks per bit, rounded to the nearest integer.
   function automatic int uart_div(input int clock, input int baud);
      return (clock + baud / 2) / baud;
   endfunction

endpackage

// File: rtl/uart_tx_bittimer.sv
// Restartable bit-period counter: counts 0..DIV-1 while run is high and flags the last count.
// It holds at zero whenever run is low, so every frame starts on a fresh bit boundary.
module uart_tx_bittimer
   import uart_pkg::*;
#(
   parameter int DIV = uart_div(25000000, 9600)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   input  logic restart,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (restart || !run || cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   assign tick = run && (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one-entry holding register feeding an 8N1/8N2 serialiser, LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLOCK     = 25000000,
   parameter int BAUD      = 9600,
   parameter int STOP_BITS = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] tx_byte,
   input  logic       tx_start,
   output logic       ready,
   output logic       busy,
   output logic       overrun,
   output logic       tx
);

   localparam int DIV = uart_div(CLOCK, BAUD);

   logic [2:0] state;
   logic [7:0] hold_data;
   logic       hold_valid;
   logic [7:0] shifter;
   logic [2:0] bit_idx;
   logic       stop_idx;
   logic       tick;
   logic       accept;
   logic       load;
   logic       stop_done;
`ifdef UART_TX_PARITY_EN
   logic       parity_bit;
`endif

   assign accept    = tx_start & ~hold_valid;
   assign stop_done = (STOP_BITS == 1) | stop_idx;
   // A queued byte enters the shifter from IDLE, or straight out of the last stop bit.
   assign load      = hold_valid & ((state == ST_IDLE) | ((state == ST_STOP) & tick & stop_done));

   uart_tx_bittimer #(.DIV(DIV)) u_bittimer (
      .clk     (clk),
      .rst_n   (rst_n),
      .run     (state != ST_IDLE),
      .restart (load),
      .tick    (tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_data  <= '0;
         hold_valid <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         if (accept) begin
            hold_data <= tx_byte;
         end
         hold_valid <= accept | (hold_valid & ~load);
         overrun    <= tx_start & hold_valid;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         tx       <= 1'b1;
         shifter  <= '0;
         bit_idx  <= '0;
         stop_idx <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_bit <= 1'b0;
`endif
      end else if (load) begin
         shifter  <= hold_data;
         tx       <= 1'b0;
         state    <= ST_START;
         bit_idx  <= '0;
         stop_idx <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_bit <= ^hold_data;
`endif
      end else if (tick) begin
         case (state)
            ST_START: begin
               tx      <= shifter[0];
               shifter <= shifter >> 1;
               state   <= ST_DATA;
            end
            ST_DATA: begin
               if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                  tx    <= parity_bit;
                  state <= ST_PARITY;
`else
                  tx    <= 1'b1;
                  state <= ST_STOP;
`endif
               end else begin
                  tx      <= shifter[0];
                  shifter <= shifter >> 1;
                  bit_idx <= bit_idx + 3'd1;
               end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
               tx    <= 1'b1;
               state <= ST_STOP;
            end
`endif
            ST_STOP: begin
               if (stop_done) begin
                  state <= ST_IDLE;
               end else begin
                  stop_idx <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign ready = ~hold_valid;
   assign busy  = (state != ST_IDLE) | hold_valid;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: two instances (1 and 2 stop bits) at DIV=16, checked
// cycle by cycle against a frame-level line model built from the byte stream.
module tb_uart_tx;

   localparam int CLK_HZ = 1600;
   localparam int BAUD   = 100;
   localparam int DIV    = 16;
`ifdef UART_TX_PARITY_EN
   localparam int PAR    = 1;
`else
   localparam int PAR    = 0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [7:0] tx_byte0 = '0, tx_byte1 = '0;
   logic       tx_start0 = 1'b0, tx_start1 = 1'b0;
   logic       ready0, busy0, overrun0, tx0;
   logic       ready1, busy1, overrun1, tx1;

   int checks = 0;
   int errors = 0;

   logic [7:0] stim_byte [8];
   int         stim_at   [8];
   bit         stim_acc  [8];
   int         stim_n;

   always #5 clk = ~clk;

   uart_tx #(.CLOCK(CLK_HZ), .BAUD(BAUD), .STOP_BITS(1)) dut_sb1 (
      .clk(clk), .rst_n(rst_n), .tx_byte(tx_byte0), .tx_start(tx_start0),
      .ready(ready0), .busy(busy0), .overrun(overrun0), .tx(tx0)
   );

   uart_tx #(.CLOCK(CLK_HZ), .BAUD(BAUD), .STOP_BITS(2)) dut_sb2 (
      .clk(clk), .rst_n(rst_n), .tx_byte(tx_byte1), .tx_start(tx_start1),
      .ready(ready1), .busy(busy1), .overrun(overrun1), .tx(tx1)
   );

   // Plays the scheduled tx_start requests into one instance and compares its line,
   // overrun, ready and busy against a bit list built from the accepted bytes.
   task automatic run_frames(input int sel, input string name);
      logic line[$];
      bit   slot_bad[$];
      logic slot_act[$];
      int   sb, total, idx;
      logic exp_tx, act_tx, act_ov, exp_ov;
      bit   idle_bad, ov_spur;
      sb = (sel == 0) ? 1 : 2;
      for (int i = 0; i < stim_n; i++) begin
         if (stim_acc[i]) begin
            line.push_back(1'b0);
            for (int b = 0; b < 8; b++) line.push_back(stim_byte[i][b]);
            if (PAR == 1) line.push_back(^stim_byte[i]);
            for (int s = 0; s < sb; s++) line.push_back(1'b1);
         end
      end
      for (int k = 0; k < line.size(); k++) begin
         slot_bad.push_back(1'b0);
         slot_act.push_back(1'b0);
      end
      total    = line.size() * DIV;
      idle_bad = 1'b0;
      ov_spur  = 1'b0;
      for (int c = 0; c <= total + 20; c++) begin
         @(negedge clk);
         idx    = c - 2;
         act_tx = (sel == 0) ? tx0 : tx1;
         act_ov = (sel == 0) ? overrun0 : overrun1;
         if (idx >= 0 && idx < total) begin
            exp_tx = line[idx / DIV];
            if (act_tx !== exp_tx && !slot_bad[idx / DIV]) begin
               slot_bad[idx / DIV] = 1'b1;
               slot_act[idx / DIV] = act_tx;
            end
         end else if (act_tx !== 1'b1) begin
            idle_bad = 1'b1;
         end
         exp_ov = 1'b0;
         for (int i = 0; i < stim_n; i++)
            if (!stim_acc[i] && stim_at[i] == c - 1) exp_ov = 1'b1;
         if (exp_ov) begin
            checks++;
            if (act_ov !== 1'b1) begin
               errors++;
               $display("FAIL %s overrun pulse at cycle %0d: got %b want 1", name, c, act_ov);
            end
         end else if (act_ov !== 1'b0) begin
            ov_spur = 1'b1;
         end
         if (c == 1) begin
            checks++;
            if (((sel == 0) ? ready0 : ready1) !== 1'b0 || ((sel == 0) ? busy0 : busy1) !== 1'b1) begin
               errors++;
               $display("FAIL %s ready/busy after accept: got %b/%b want 0/1", name,
                        (sel == 0) ? ready0 : ready1, (sel == 0) ? busy0 : busy1);
            end
         end
         if (c == total + 1) begin
            checks++;
            if (((sel == 0) ? busy0 : busy1) !== 1'b1) begin
               errors++;
               $display("FAIL %s busy in last stop cycle: got 0 want 1", name);
            end
         end
         if (c == total + 2) begin
            checks++;
            if (((sel == 0) ? busy0 : busy1) !== 1'b0 || ((sel == 0) ? ready0 : ready1) !== 1'b1) begin
               errors++;
               $display("FAIL %s busy/ready after %0d clocks: got %b/%b want 0/1", name, total,
                        (sel == 0) ? busy0 : busy1, (sel == 0) ? ready0 : ready1);
            end
         end
         tx_start0 = 1'b0;
         tx_start1 = 1'b0;
         for (int i = 0; i < stim_n; i++) begin
            if (stim_at[i] == c) begin
               if (sel == 0) begin tx_byte0 = stim_byte[i]; tx_start0 = 1'b1; end
               else          begin tx_byte1 = stim_byte[i]; tx_start1 = 1'b1; end
            end
         end
      end
      for (int k = 0; k < line.size(); k++) begin
         checks++;
         if (slot_bad[k]) begin
            errors++;
            $display("FAIL %s line bit %0d: got %b want %b", name, k, slot_act[k], line[k]);
         end
      end
      checks++;
      if (idle_bad) begin
         errors++;
         $display("FAIL %s idle line: got 0 outside frame want 1", name);
      end
      checks++;
      if (ov_spur) begin
         errors++;
         $display("FAIL %s overrun: got spurious pulse want 0", name);
      end
   endtask

   task automatic one_byte(input int sel, input logic [7:0] b, input string name);
      stim_n = 1; stim_byte[0] = b; stim_at[0] = 0; stim_acc[0] = 1'b1;
      run_frames(sel, name);
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if ({tx0, ready0, busy0, overrun0} !== 4'b1100 || {tx1, ready1, busy1, overrun1} !== 4'b1100) begin
         errors++;
         $display("FAIL reset outputs tx/ready/busy/ovr: got %b%b%b%b %b%b%b%b want 1100 1100",
                  tx0, ready0, busy0, overrun0, tx1, ready1, busy1, overrun1);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_single_byte();
      one_byte(0, 8'hA5, "single_A5");
      for (int r = 0; r < 3; r++) one_byte(0, 8'($urandom), "single_rand");
   endtask

   task automatic test_back_to_back();
      stim_n = 2;
      stim_byte[0] = 8'h00; stim_at[0] = 0;  stim_acc[0] = 1'b1;
      stim_byte[1] = 8'hFF; stim_at[1] = 40; stim_acc[1] = 1'b1;
      run_frames(0, "b2b_00_FF");
      stim_byte[0] = 8'($urandom); stim_byte[1] = 8'($urandom);
      stim_at[1] = int'($urandom_range(20, 150));
      run_frames(0, "b2b_rand");
   endtask

   task automatic test_overrun();
      stim_n = 3;
      stim_byte[0] = 8'($urandom); stim_at[0] = 0;  stim_acc[0] = 1'b1;
      stim_byte[1] = 8'($urandom); stim_at[1] = 40; stim_acc[1] = 1'b1;
      stim_byte[2] = 8'h55;        stim_at[2] = 41; stim_acc[2] = 1'b0;
      run_frames(0, "overrun");
   endtask

   task automatic test_two_stop_bits();
      one_byte(1, 8'h3C, "stop2_3C");
      one_byte(1, 8'($urandom), "stop2_rand");
      stim_n = 2;
      stim_byte[0] = 8'($urandom); stim_at[0] = 0;  stim_acc[0] = 1'b1;
      stim_byte[1] = 8'($urandom); stim_at[1] = 90; stim_acc[1] = 1'b1;
      run_frames(1, "stop2_b2b");
   endtask

   task automatic test_reset_mid_frame();
      @(negedge clk);
      tx_byte0 = 8'h00; tx_start0 = 1'b1;
      @(negedge clk);
      tx_start0 = 1'b0;
      // Start bit plus data bits 0..2 is 64 clocks; land in the middle of bit 3.
      repeat (71) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({tx0, busy0, ready0} !== 3'b101) begin
         errors++;
         $display("FAIL reset_mid tx/busy/ready: got %b%b%b want 101", tx0, busy0, ready0);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      one_byte(0, 8'h81, "after_reset_81");
   endtask

`ifdef UART_TX_PARITY_EN
   task automatic test_parity();
      one_byte(0, 8'h07, "parity_07");
      one_byte(0, 8'h03, "parity_03");
      one_byte(1, 8'($urandom), "parity_stop2_rand");
   endtask
`endif

   initial begin
      test_reset();
      test_single_byte();
      test_back_to_back();
      test_overrun();
      test_two_stop_bits();
      test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
      test_parity();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
